// File: rtl/uart_wb_arbiter.sv
// uart_wb_arbiter
// Lets two masters share the single UART register port. Only one transaction runs at a
// time. When both masters request together, round-robin priority picks the winner. The
// UART strobe is held until the UART acks or a timeout expires. The winner then gets a
// one-cycle ack (with read data) or a one-cycle err pulse.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   m0_* / m1_*             master request (stb/we/addr/data_in) and response
//                           (data_out/ack/err)
//   s_stb/s_we/s_addr/
//   s_data_out              request driven to the UART, held for the whole transaction
//   s_data_in, s_ack        UART read data and acknowledge
//   grant                   one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
module uart_wb_arbiter #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  // master 0
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data_in,
  output logic [DATA_W-1:0] m0_data_out,
  output logic              m0_ack,
  output logic              m0_err,
  // master 1
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data_in,
  output logic [DATA_W-1:0] m1_data_out,
  output logic              m1_ack,
  output logic              m1_err,
  // UART side
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data_out,
  input  logic [DATA_W-1:0] s_data_in,
  input  logic              s_ack,
  output logic [1:0]        grant
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;    // master that wins the next tie (0 = m0)
  logic              owner_q, owner_d;  // master owning the current transaction
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ack_q, ack_d;      // {m1, m0}
  logic [1:0]        err_q, err_d;      // {m1, m0}
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_d  = grant_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack_d    = 2'b00;  // pulses last a single cycle
    err_d    = 2'b00;
    pick     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (m0_stb || m1_stb) begin
          // A lone requester always wins; a tie goes to the pointer.
          pick    = (m0_stb && m1_stb) ? prio_q : m1_stb;
          owner_d = pick;
          prio_d  = ~pick;
          we_d    = pick ? m1_we      : m0_we;
          addr_d  = pick ? m1_addr    : m0_addr;
          wdata_d = pick ? m1_data_in : m0_data_in;
          grant_d = pick ? 2'b10      : 2'b01;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (s_ack) begin
          // Ack takes precedence over a timeout expiring in the same cycle.
          if (owner_q) begin
            rdata1_d = s_data_in;
          end else begin
            rdata0_d = s_data_in;
          end
          ack_d   = owner_q ? 2'b10 : 2'b01;
          stb_d   = 1'b0;
          grant_d = 2'b00;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = owner_q ? 2'b10 : 2'b01;
          stb_d   = 1'b0;
          grant_d = 2'b00;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= 2'b00;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign s_stb       = stb_q;
  assign s_we        = we_q;
  assign s_addr      = addr_q;
  assign s_data_out  = wdata_q;
  assign grant       = grant_q;
  assign m0_ack      = ack_q[0];
  assign m1_ack      = ack_q[1];
  assign m0_err      = err_q[0];
  assign m1_err      = err_q[1];
  assign m0_data_out = rdata0_q;
  assign m1_data_out = rdata1_q;

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed testbench for uart_wb_arbiter (ADDR_W=2, DATA_W=8, TIMEOUT=16).
// A small UART responder acks a programmable number of cycles after s_stb rises.
module tb_uart_wb_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_stb, m0_we, m1_stb, m1_we;
  logic [1:0] m0_addr, m1_addr;
  logic [7:0] m0_data_in, m1_data_in, m0_data_out, m1_data_out;
  logic       m0_ack, m0_err, m1_ack, m1_err;
  logic       s_stb, s_we, s_ack;
  logic [1:0] s_addr, grant;
  logic [7:0] s_data_out, s_data_in;

  logic [7:0] ack_delay;
  logic [7:0] hold_cnt;
  logic       force_ack;

  int checks = 0;
  int errors = 0;

  uart_wb_arbiter #(.ADDR_W(2), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_stb     (m0_stb),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_data_in (m0_data_in),
    .m0_data_out(m0_data_out),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m1_stb     (m1_stb),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_data_in (m1_data_in),
    .m1_data_out(m1_data_out),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .s_stb      (s_stb),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_data_out (s_data_out),
    .s_data_in  (s_data_in),
    .s_ack      (s_ack),
    .grant      (grant)
  );

  always #5 clk = ~clk;

  // hold_cnt counts edges with s_stb high; ack is presented when it equals ack_delay.
  always_ff @(posedge clk) begin
    if (!s_stb) hold_cnt <= 8'd0;
    else        hold_cnt <= hold_cnt + 8'd1;
  end
  assign s_ack = force_ack | (s_stb & (hold_cnt == ack_delay));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    m0_stb = 0; m0_we = 0; m0_addr = 0; m0_data_in = 0;
    m1_stb = 0; m1_we = 0; m1_addr = 0; m1_data_in = 0;
    s_data_in = 8'h00; ack_delay = 8'd255; force_ack = 1'b0;
    tick(); tick();
    checks++;
    if ({s_stb, s_we, s_addr, s_data_out, grant} !== 14'h0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", {s_stb, s_we, s_addr, s_data_out, grant});
    end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
      errors++; $display("FAIL reset_pulse: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    checks++;
    if ({m0_data_out, m1_data_out} !== 16'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0000", {m0_data_out, m1_data_out});
    end
    reset = 1'b1;
  endtask

  task automatic test_write_ack;
    ack_delay = 8'd2;
    m0_stb = 1; m0_we = 1; m0_addr = 2'd0; m0_data_in = 8'h41;
    tick();
    m0_stb = 0;
    checks++;
    if ({s_stb, s_we, s_addr, s_data_out, grant} !== {1'b1, 1'b1, 2'd0, 8'h41, 2'b01}) begin
      errors++; $display("FAIL wr_grant: got %h expected %h",
                         {s_stb, s_we, s_addr, s_data_out, grant}, {1'b1, 1'b1, 2'd0, 8'h41, 2'b01});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({s_stb, s_we, s_addr, s_data_out, grant, m0_ack} !== {1'b1, 1'b1, 2'd0, 8'h41, 2'b01, 1'b0}) begin
        errors++; $display("FAIL wr_hold%0d: got %h expected %h", i,
                           {s_stb, s_we, s_addr, s_data_out, grant, m0_ack},
                           {1'b1, 1'b1, 2'd0, 8'h41, 2'b01, 1'b0});
      end
    end
    tick();
    checks++;
    if ({m0_ack, m0_err, s_stb, grant} !== 5'b10000) begin
      errors++; $display("FAIL wr_ack: got %b expected 10000", {m0_ack, m0_err, s_stb, grant});
    end
    tick();
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++; $display("FAIL wr_ack_pulse: got %b expected 0", m0_ack);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp;
    reset = 1'b0; tick(); reset = 1'b1;
    ack_delay = 8'd0; s_data_in = 8'h33;
    m0_stb = 1; m0_we = 0; m0_addr = 2'd1;
    m1_stb = 1; m1_we = 0; m1_addr = 2'd3;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1) ? 2'b10 : 2'b01;
      tick();
      checks++;
      if ({grant, s_addr} !== {exp, (i % 2 == 1) ? 2'd3 : 2'd1}) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, {grant, s_addr},
                           {exp, (i % 2 == 1) ? 2'd3 : 2'd1});
      end
      if (i == 3) begin
        m0_stb = 0; m1_stb = 0;
      end
      tick();
      checks++;
      if ({m1_ack, m0_ack, m1_err, m0_err, grant} !== {exp, 4'b0000}) begin
        errors++; $display("FAIL rr_ack%0d: got %b expected %b", i,
                           {m1_ack, m0_ack, m1_err, m0_err, grant}, {exp, 4'b0000});
      end
      tick();
    end
  endtask

  task automatic test_read_m1;
    s_data_in = 8'h5A; ack_delay = 8'd0;
    m1_stb = 1; m1_we = 0; m1_addr = 2'd2;
    tick();
    m1_stb = 0;
    checks++;
    if ({grant, s_we, s_addr} !== {2'b10, 1'b0, 2'd2}) begin
      errors++; $display("FAIL rd_grant: got %b expected 10010", {grant, s_we, s_addr});
    end
    tick();
    checks++;
    if ({m1_ack, m1_data_out} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL rd_m1: got %h expected 15a", {m1_ack, m1_data_out});
    end
    checks++;
    if ({m0_ack, m0_err, m0_data_out} !== {2'b00, 8'h33}) begin
      errors++; $display("FAIL rd_m0_quiet: got %h expected 033", {m0_ack, m0_err, m0_data_out});
    end
    tick();
  endtask

  task automatic test_timeout;
    ack_delay = 8'd255;
    m0_stb = 1; m0_we = 1; m0_addr = 2'd1; m0_data_in = 8'h77;
    tick();
    m0_stb = 0;
    checks++;
    if ({s_stb, grant} !== 3'b101) begin
      errors++; $display("FAIL to_grant: got %b expected 101", {s_stb, grant});
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if ({s_stb, m0_err, m0_ack} !== 3'b100) begin
        errors++; $display("FAIL to_wait%0d: got %b expected 100", i, {s_stb, m0_err, m0_ack});
      end
    end
    tick();
    checks++;
    if ({s_stb, grant, m0_err, m0_ack, m0_data_out} !== {5'b00010, 8'h33}) begin
      errors++; $display("FAIL to_err: got %h expected %h",
                         {s_stb, grant, m0_err, m0_ack, m0_data_out}, {5'b00010, 8'h33});
    end
    tick();
    checks++;
    if (m0_err !== 1'b0) begin
      errors++; $display("FAIL to_err_pulse: got %b expected 0", m0_err);
    end
  endtask

  task automatic test_ack_at_timeout;
    ack_delay = 8'd15; s_data_in = 8'hC3;
    m0_stb = 1; m0_we = 0; m0_addr = 2'd0;
    tick();
    m0_stb = 0;
    for (int i = 1; i < 16; i++) tick();
    tick();
    checks++;
    if ({m0_ack, m0_err, m0_data_out} !== {2'b10, 8'hC3}) begin
      errors++; $display("FAIL ack_vs_to: got %h expected 2c3", {m0_ack, m0_err, m0_data_out});
    end
    tick();
  endtask

  task automatic test_idle_ack;
    force_ack = 1'b1;
    tick(); tick();
    checks++;
    if ({s_stb, grant, m0_ack, m1_ack, m0_err, m1_err, m0_data_out, m1_data_out}
        !== {7'b0, 8'hC3, 8'h5A}) begin
      errors++; $display("FAIL idle_ack: got %h expected %h",
                         {s_stb, grant, m0_ack, m1_ack, m0_err, m1_err, m0_data_out, m1_data_out},
                         {7'b0, 8'hC3, 8'h5A});
    end
    force_ack = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    ack_delay = 8'd255;
    m1_stb = 1; m1_we = 1; m1_addr = 2'd1; m1_data_in = 8'h12;
    tick();
    m1_stb = 0;
    checks++;
    if (grant !== 2'b10) begin
      errors++; $display("FAIL rmb_grant: got %b expected 10", grant);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({s_stb, grant, m1_ack, m1_err, m0_ack, m0_err} !== 7'b0) begin
      errors++; $display("FAIL rmb_abort: got %b expected 0000000",
                         {s_stb, grant, m1_ack, m1_err, m0_ack, m0_err});
    end
    reset = 1'b1;
    m0_stb = 1; m1_stb = 1;
    tick();
    m0_stb = 0; m1_stb = 0;
    ack_delay = 8'd0;
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL rmb_tie: got %b expected 01", grant);
    end
    tick();
    checks++;
    if ({m0_ack, m1_ack} !== 2'b10) begin
      errors++; $display("FAIL rmb_ack: got %b expected 10", {m0_ack, m1_ack});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_round_robin();
    test_read_m1();
    test_timeout();
    test_ack_at_timeout();
    test_idle_ack();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
